// File: rtl/gs_pkg.sv
// ============================================================================
// gs_pkg: shared geometry and state encoding for the LED-panel image path.
// Rev 1.0
// ============================================================================
`default_nettype none

package gs_pkg;

   localparam int INDEX_MAX = 576;
   localparam int ROWS      = 8;
   localparam int CHAINS    = 12;
   localparam int GS_BITS   = 12;
   localparam int SLOTS     = INDEX_MAX / GS_BITS;
   localparam int ADDR_W    = 13;

   localparam int CHAIN_W = $clog2(CHAINS);
   localparam int BIT_W   = $clog2(GS_BITS);
   localparam int SLOT_W  = $clog2(SLOTS);
   localparam int ROW_W   = $clog2(ROWS);

   typedef enum logic [0:0] {
      COLLECT = 1'b0,
      EMIT    = 1'b1
   } state_e;

endpackage

`default_nettype wire

// File: rtl/gs_transpose_buf.sv
// ============================================================================
// gs_transpose_buf: CHAINS x GS_BITS register file, written per chain and read
// as one bit-plane across all chains. Rev 1.0
// ============================================================================
`default_nettype none

module gs_transpose_buf
   import gs_pkg::*;
(
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               wr_en_i,
   input  logic [CHAIN_W-1:0] wr_chain_i,
   input  logic [GS_BITS-1:0] wr_data_i,
   input  logic [BIT_W-1:0]   rd_bit_i,
   output logic [CHAINS-1:0]  rd_plane_o
);

   logic [GS_BITS-1:0] buf_q [CHAINS];

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         for (int i = 0; i < CHAINS; i++) begin
            buf_q[i] <= '0;
         end
      end else if (wr_en_i) begin
         buf_q[wr_chain_i] <= wr_data_i;
      end
   end

   for (genvar c = 0; c < CHAINS; c++) begin : g_plane
      assign rd_plane_o[c] = buf_q[c][rd_bit_i];
   end

endmodule

`default_nettype wire

// File: rtl/gs_frame_loader.sv
// ============================================================================
// gs_frame_loader: collects one pixel per chain, then writes the slot as
// GS_BITS bit-plane words into the scan engine's image RAM. Rev 1.0
// ============================================================================
`default_nettype none

module gs_frame_loader
   import gs_pkg::*;
(
   input  logic               clock_i,
   input  logic               reset_i,
   input  logic               pix_valid_i,
   output logic               pix_ready_o,
   input  logic [GS_BITS-1:0] pix_data_i,
   input  logic               pix_sof_i,
   output logic               wr_en_o,
   output logic [ADDR_W-1:0]  wr_addr_o,
   output logic [CHAINS-1:0]  wr_data_o,
   output logic               frame_done_o,
   output logic               sof_error_o
);

   localparam logic [CHAIN_W-1:0] CHAIN_LAST = CHAIN_W'(CHAINS - 1);
   localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(GS_BITS - 1);
   localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SLOTS - 1);
   localparam logic [ROW_W-1:0]   ROW_LAST   = ROW_W'(ROWS - 1);
   localparam logic [ADDR_W-1:0]  SLOT_STEP  = ADDR_W'(GS_BITS);

   state_e              state_q, state_d;
   logic                run_q;
   logic [CHAIN_W-1:0]  chain_q, chain_d;
   logic [SLOT_W-1:0]   slot_q, slot_d;
   logic [ROW_W-1:0]    row_q, row_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic                sof_err_q, sof_err_d;
   logic                wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [CHAINS-1:0]   wr_data_q, wr_data_d;
   logic                frame_done_q, frame_done_d;

   logic                w_xfer;
   logic [CHAIN_W-1:0]  w_buf_idx;
   logic [CHAINS-1:0]   w_plane;

   // run_q holds ready low while reset is asserted and for the edge it releases on.
   assign pix_ready_o = run_q && (state_q == COLLECT);
   assign w_xfer      = pix_valid_i && pix_ready_o;

   gs_transpose_buf u_buf (
      .clock_i    (clock_i),
      .reset_i    (reset_i),
      .wr_en_i    (w_xfer),
      .wr_chain_i (w_buf_idx),
      .wr_data_i  (pix_data_i),
      .rd_bit_i   (bit_q),
      .rd_plane_o (w_plane)
   );

   always_comb begin
      state_d      = state_q;
      chain_d      = chain_q;
      slot_d       = slot_q;
      row_d        = row_q;
      bit_d        = bit_q;
      base_d       = base_q;
      sof_err_d    = sof_err_q;
      wr_en_d      = 1'b0;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      frame_done_d = 1'b0;
      w_buf_idx    = chain_q;

      case (state_q)
         COLLECT: begin
            if (w_xfer) begin
               if (pix_sof_i) begin
                  // Restart the frame: the partial slot is dropped by restarting at chain 0.
                  if ((chain_q != '0) || (slot_q != '0) || (row_q != '0)) begin
                     sof_err_d = 1'b1;
                  end
                  w_buf_idx = '0;
                  chain_d   = CHAIN_W'(1);
                  slot_d    = '0;
                  row_d     = '0;
                  base_d    = '0;
               end else if (chain_q == CHAIN_LAST) begin
                  chain_d = '0;
                  bit_d   = BIT_LAST;
                  state_d = EMIT;
               end else begin
                  chain_d = chain_q + 1'b1;
               end
            end
         end

         EMIT: begin
            wr_en_d   = 1'b1;
            wr_data_d = w_plane;
            wr_addr_d = base_q + ADDR_W'(BIT_LAST - bit_q);
            if (bit_q == '0) begin
               state_d      = COLLECT;
               frame_done_d = (slot_q == SLOT_LAST) && (row_q == ROW_LAST);
               // Slots are contiguous across rows, so the base only rewinds at frame end.
               if (slot_q == SLOT_LAST) begin
                  slot_d = '0;
                  if (row_q == ROW_LAST) begin
                     row_d  = '0;
                     base_d = '0;
                  end else begin
                     row_d  = row_q + 1'b1;
                     base_d = base_q + SLOT_STEP;
                  end
               end else begin
                  slot_d = slot_q + 1'b1;
                  base_d = base_q + SLOT_STEP;
               end
            end else begin
               bit_d = bit_q - 1'b1;
            end
         end

         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q      <= COLLECT;
         run_q        <= 1'b0;
         chain_q      <= '0;
         slot_q       <= '0;
         row_q        <= '0;
         bit_q        <= '0;
         base_q       <= '0;
         sof_err_q    <= 1'b0;
         wr_en_q      <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         run_q        <= 1'b1;
         chain_q      <= chain_d;
         slot_q       <= slot_d;
         row_q        <= row_d;
         bit_q        <= bit_d;
         base_q       <= base_d;
         sof_err_q    <= sof_err_d;
         wr_en_q      <= wr_en_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign wr_en_o      = wr_en_q;
   assign wr_addr_o    = wr_addr_q;
   assign wr_data_o    = wr_data_q;
   assign frame_done_o = frame_done_q;
   assign sof_error_o  = sof_err_q;

endmodule

`default_nettype wire

// File: tb/tb_gs_frame_loader.sv
// ============================================================================
// tb_gs_frame_loader: scoreboard bench; expected RAM writes are queued as each
// slot completes and compared as the loader emits them. Rev 1.0
// ============================================================================
`default_nettype none

module tb_gs_frame_loader;
   import gs_pkg::*;

   logic               clock;
   logic               reset;
   logic               pix_valid;
   logic               pix_ready_o;
   logic [GS_BITS-1:0] pix_data;
   logic               pix_sof;
   logic               wr_en_o;
   logic [ADDR_W-1:0]  wr_addr_o;
   logic [CHAINS-1:0]  wr_data_o;
   logic               frame_done_o;
   logic               sof_error_o;

   gs_frame_loader dut (
      .clock_i      (clock),
      .reset_i      (reset),
      .pix_valid_i  (pix_valid),
      .pix_ready_o  (pix_ready_o),
      .pix_data_i   (pix_data),
      .pix_sof_i    (pix_sof),
      .wr_en_o      (wr_en_o),
      .wr_addr_o    (wr_addr_o),
      .wr_data_o    (wr_data_o),
      .frame_done_o (frame_done_o),
      .sof_error_o  (sof_error_o)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [CHAINS-1:0] data;
      logic              fd;
   } exp_t;

   exp_t sbq[$];

   int n_checks = 0;
   int n_fail   = 0;

   logic [GS_BITS-1:0] m_buf [CHAINS];
   int m_chain, m_slot, m_row;

   int wr_cnt, first_addr, fd_cnt, fd_addr, hit_r2s3;
   int seen [INDEX_MAX*ROWS];

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_clear();
      sbq.delete();
      m_chain = 0;
      m_slot  = 0;
      m_row   = 0;
      for (int c = 0; c < CHAINS; c++) m_buf[c] = '0;
   endfunction

   function automatic void model_accept(input logic [GS_BITS-1:0] d, input logic s);
      exp_t e;
      if (s) begin
         m_chain = 0;
         m_slot  = 0;
         m_row   = 0;
      end
      m_buf[m_chain] = d;
      m_chain++;
      if (m_chain == CHAINS) begin
         m_chain = 0;
         for (int b = GS_BITS - 1; b >= 0; b--) begin
            e.addr = ADDR_W'(m_row * INDEX_MAX + m_slot * GS_BITS + (GS_BITS - 1 - b));
            for (int c = 0; c < CHAINS; c++) e.data[c] = m_buf[c][b];
            e.fd = (m_row == ROWS - 1) && (m_slot == SLOTS - 1) && (b == 0);
            sbq.push_back(e);
         end
         m_slot++;
         if (m_slot == SLOTS) begin
            m_slot = 0;
            m_row  = (m_row + 1) % ROWS;
         end
      end
   endfunction

   // Monitor: sampled on the falling edge, away from the register updates.
   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         if (wr_en_o) begin
            if (wr_cnt == 0) first_addr = int'(wr_addr_o);
            wr_cnt++;
            if (int'(wr_addr_o) < INDEX_MAX * ROWS) seen[wr_addr_o]++;
            if (wr_addr_o >= 13'd1188 && wr_addr_o <= 13'd1199) hit_r2s3++;
            if (frame_done_o) begin
               fd_cnt++;
               fd_addr = int'(wr_addr_o);
            end
            chk_eq("sb_nonempty", (sbq.size() != 0), 1);
            if (sbq.size() != 0) begin
               e = sbq.pop_front();
               chk_eq("wr_addr", wr_addr_o, e.addr);
               chk_eq("wr_data", wr_data_o, e.data);
               chk_eq("frame_done", frame_done_o, e.fd);
            end
         end else begin
            chk_eq("fd_idle", frame_done_o, 0);
         end
      end
   end

   task automatic send_pix(input logic [GS_BITS-1:0] d, input logic s);
      int n;
      pix_valid = 1'b1;
      pix_data  = d;
      pix_sof   = s;
      n = 0;
      while (!pix_ready_o && n < 64) begin
         @(negedge clock);
         n++;
      end
      chk_eq("ready_wait", pix_ready_o, 1);
      if (pix_ready_o) begin
         @(posedge clock);
         model_accept(d, s);
         @(negedge clock);
      end
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset     = 1'b1;
      pix_valid = 1'b0;
      pix_sof   = 1'b0;
      model_clear();
      repeat (2) @(negedge clock);
      chk_eq("rst_ready", pix_ready_o, 0);
      chk_eq("rst_wr_en", wr_en_o, 0);
      chk_eq("rst_wr_addr", wr_addr_o, 0);
      chk_eq("rst_wr_data", wr_data_o, 0);
      chk_eq("rst_frame_done", frame_done_o, 0);
      chk_eq("rst_sof_error", sof_error_o, 0);
      reset = 1'b0;
      @(negedge clock);
      chk_eq("ready_after_rst", pix_ready_o, 1);
   endtask

   task automatic drain();
      repeat (16) @(negedge clock);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n, bad;
      reset     = 1'b1;
      pix_valid = 1'b0;
      pix_data  = '0;
      pix_sof   = 1'b0;
      wr_cnt = 0; first_addr = -1; fd_cnt = 0; fd_addr = -1; hit_r2s3 = 0;
      model_clear();
      repeat (2) @(negedge clock);

      // Single MSB on chain 0, with a legal leading sof.
      do_reset();
      wr_cnt = 0;
      for (int c = 0; c < CHAINS; c++) send_pix((c == 0) ? 12'h800 : 12'h000, (c == 0));
      n = 0;
      while (!pix_ready_o && n < 50) begin
         n++;
         @(negedge clock);
      end
      chk_eq("ready_low_cycles", n, 12);
      drain();
      chk_eq("t1_writes", wr_cnt, 12);
      chk_eq("t1_first_addr", first_addr, 0);
      chk_eq("t1_sof_error", sof_error_o, 0);

      // One-hot pixel per chain.
      for (int c = 0; c < CHAINS; c++) send_pix(GS_BITS'(1 << c), 1'b0);
      drain();

      // Full frame.
      do_reset();
      foreach (seen[i]) seen[i] = 0;
      wr_cnt = 0; fd_cnt = 0; fd_addr = -1;
      for (int p = 0; p < INDEX_MAX * ROWS; p++) send_pix(GS_BITS'($urandom), 1'b0);
      drain();
      bad = 0;
      foreach (seen[i]) if (seen[i] != 1) bad++;
      chk_eq("frame_writes", wr_cnt, INDEX_MAX * ROWS);
      chk_eq("addr_cover", bad, 0);
      chk_eq("fd_count", fd_cnt, 1);
      chk_eq("fd_addr", fd_addr, 4607);
      wr_cnt = 0;
      for (int c = 0; c < CHAINS; c++) send_pix(GS_BITS'($urandom), 1'b0);
      drain();
      chk_eq("wrap_first_addr", first_addr, 0);

      // Mid-frame sof at row 2, slot 3, pixel 5.
      do_reset();
      hit_r2s3 = 0;
      for (int p = 0; p < (2 * SLOTS + 3) * CHAINS + 4; p++) send_pix(GS_BITS'($urandom), 1'b0);
      chk_eq("pre_sof_error", sof_error_o, 0);
      drain();
      wr_cnt = 0;
      for (int c = 0; c < CHAINS; c++) send_pix(12'hA5A, (c == 0));
      drain();
      chk_eq("sof_error_set", sof_error_o, 1);
      chk_eq("sof_first_addr", first_addr, 0);
      chk_eq("sof_writes", wr_cnt, 12);
      chk_eq("r2s3_hits", hit_r2s3, 0);

      // Reset during the sixth EMIT cycle.
      do_reset();
      for (int c = 0; c < CHAINS; c++) send_pix(GS_BITS'($urandom), 1'b0);
      repeat (5) @(negedge clock);
      chk_eq("emit_wr_en_pre", wr_en_o, 1);
      #1 reset = 1'b1;
      #1;
      chk_eq("emit_rst_wr_en", wr_en_o, 0);
      chk_eq("emit_rst_ready", pix_ready_o, 0);
      model_clear();
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      wr_cnt = 0;
      for (int c = 0; c < CHAINS; c++) send_pix(GS_BITS'($urandom), 1'b0);
      drain();
      chk_eq("post_rst_first_addr", first_addr, 0);
      chk_eq("post_rst_writes", wr_cnt, 12);

      // Bursty valid with all-ones data; idle cycles carry junk on data and sof.
      wr_cnt = 0;
      for (int p = 0; p < 4 * CHAINS; p++) begin
         repeat ($urandom_range(0, 2)) begin
            pix_valid = 1'b0;
            pix_data  = GS_BITS'($urandom);
            pix_sof   = 1'($urandom_range(0, 1));
            @(negedge clock);
         end
         send_pix(12'hFFF, 1'b0);
      end
      drain();
      chk_eq("burst_writes", wr_cnt, 4 * CHAINS);
      chk_eq("burst_sof_error", sof_error_o, 0);

      chk_eq("sb_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/gs_frame_loader.md
Name: gs_frame_loader

Overview:
- Upstream stage of the LED-panel scan/shift engine. It fills that engine's bit-sliced image RAM from a live pixel stream, replacing the static hex image.
- Accepts 12-bit grayscale pixels, one per driver chain, and buffers one slot (all 12 chains).
- Transposes the slot into 12 bit-plane words, one per serial shift position, and writes them at the addresses the scan engine reads.
- Data-word bit c drives serial-data line c: chains 0-5 are the left lines 1-6, chains 6-11 are the right lines 1-6.

Parameters:
- INDEX_MAX, 576: shift positions per row per chain (3 drivers x 16 channels x 12 bits).
- ROWS, 8: multiplexed rows per frame; each row occupies INDEX_MAX consecutive RAM words.
- CHAINS, 12: parallel serial-data lines; equals the RAM word width.
- GS_BITS, 12: grayscale bits per pixel. SLOTS = INDEX_MAX/GS_BITS = 48.

Ports:
- clock, in, 1: single system clock; all logic on its rising edge.
- reset, in, 1: asynchronous, active-high; clears all state immediately.
- pix_valid, in, 1: upstream pixel valid.
- pix_ready, out, 1: block can accept a pixel.
- pix_data, in, GS_BITS: grayscale value, MSB first in the shift order.
- pix_sof, in, 1: qualifies the pixel as row 0, slot 0, chain 0.
- wr_en, out, 1: image RAM write strobe.
- wr_addr, out, 13: image RAM word address.
- wr_data, out, CHAINS: bit-plane word.
- frame_done, out, 1: one-cycle pulse on the final write of a frame.
- sof_error, out, 1: sticky flag, set when pix_sof arrives mid-frame.

Behaviour:
- Reset values: pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, frame_done=0, sof_error=0. The counters chain, slot, row and bit are all 0. State is COLLECT; pix_ready rises on the first clock after reset deasserts.
- Handshake: a pixel transfers on a rising edge with pix_valid && pix_ready. pix_ready is combinational from state (1 in COLLECT, 0 in EMIT), never from pix_valid. pix_data and pix_sof are ignored unless a transfer occurs.
- COLLECT:
  - A transfer stores pix_data into buf[chain] and increments chain.
  - On the transfer with chain==CHAINS-1, chain wraps to 0, bit is set to GS_BITS-1, and the next state is EMIT.
- EMIT (exactly GS_BITS cycles, registered outputs):
  - Each cycle: wr_en=1, wr_data[c]=buf[c][bit] for every c.
  - wr_addr = row*INDEX_MAX + slot*GS_BITS + (GS_BITS-1-bit), so addresses ascend through the slot, MSB plane first.
  - bit decrements each cycle.
  - After the bit==0 write, the next state is COLLECT; slot increments and wraps at SLOTS-1, incrementing row; row wraps at ROWS-1 to 0.
  - frame_done=1 coincident with the write at row=ROWS-1, slot=SLOTS-1, bit=0.
  - Throughput is 12 pixels per 24 cycles; first write one cycle after the 12th accepted pixel.
- Address width: row*INDEX_MAX is at most 4032 and the maximum address is 4607, so it fits in 13 bits. Compute the address with a running base register (add INDEX_MAX per row, GS_BITS per slot), not a multiplier.
- pix_sof handling:
  - A transfer with pix_sof=1 forces chain, slot and row to 0 before storing, so the pixel lands in buf[0].
  - If chain, slot or row was nonzero at that moment, any partially collected buffer is discarded and sof_error sets. sof_error clears only on reset.
  - pix_sof with all counters already 0 is legal and silent.
- Stream with no pix_sof: position counting runs free from reset; the first pixel after reset is row 0, slot 0, chain 0.
- Reset mid-EMIT: wr_en drops asynchronously; partial slot writes are not completed.
- No back-pressure from the RAM: writes are assumed accepted every cycle.
- The RAM is dual-port; tearing against the scan engine's reads is acceptable.

Decomposition:
- Shared package gs_pkg: INDEX_MAX, ROWS, CHAINS, GS_BITS, SLOTS, ADDR_W=13, and the state enum {COLLECT, EMIT}.
- The scan engine's defaults come from the same package.
- Sub-module gs_transpose_buf: 12x12 register file with write-by-chain and read-by-bit-plane ports. It is purely storage plus mux; the FSM and counters stay in the top level.

Test Plan:
- Reset, then 12 pixels with pix_sof on the first, pix_data = 12'h800 on chain 0 and 0 elsewhere -> 12 writes to addr 0..11; wr_data=12'h001 at addr 0, 12'h000 at addr 1..11; pix_ready low for exactly 12 cycles.
- Chain c sends value 1<<c for c=0..11 -> at addr 11-c, wr_data has only bit c set; every other written word is 0.
- Full frame of 8*48*12 = 4608 pixels -> 4608 writes; addresses cover 0..4607 exactly once; frame_done pulses once at addr 4607; the next pixel writes to addr 0.
- pix_sof asserted on pixel 5 of row 2, slot 3 -> sof_error=1; the next write burst starts at addr 0; no write ever targets row 2, slot 3 for the discarded data.
- Reset asserted during the 6th EMIT cycle -> wr_en=0 and pix_ready=0 in the same cycle; after release, the first burst writes addr 0.
- pix_valid toggled randomly with 12'hFFF data -> every write is 12'hFFF, address order is unchanged, and no pixel is lost or duplicated.
